// File: rtl/seq_cla_adder_ctrl_pkg.sv
// Shared FSM state encoding and default operand size for the sequential CLA adder.
package seq_cla_adder_ctrl_pkg;

  localparam int NIBBLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/seq_cla_adder_ctrl_if.sv
// Request/result bundle for the sequential adder: operands in, registered sum and status out.
interface seq_cla_adder_ctrl_if
  import seq_cla_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic [W-1:0] S;
  logic         cout;
  logic         busy;
  logic         done;

  modport master (output start, A, B, cin, input S, cout, busy, done);
  modport slave  (input start, A, B, cin, output S, cout, busy, done);

endinterface

// File: rtl/bit_4_augment.sv
// 4-bit carry-lookahead slice with group propagate/generate; purely combinational.
// Zero latency, no flow control.
module bit_4_augment (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] S,
  output logic       p,
  output logic       g
);

  logic [3:0] prop;
  logic [3:0] gen;
  logic [3:0] c;

  assign prop = A ^ B;
  assign gen  = A & B;

  assign c[0] = cin;
  assign c[1] = gen[0] | (prop[0] & cin);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & cin);

  assign S = prop ^ c;
  assign p = &prop;
  assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0]);

endmodule

// File: rtl/seq_cla_adder_ctrl.sv
// Adds two W-bit operands one nibble per cycle through a single CLA slice; done NIBBLES+1 cycles after accept.
// No backpressure: start is only sampled in IDLE and ignored while busy.
module seq_cla_adder_ctrl
  import seq_cla_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
)(
  input  logic                 clk,
  input  logic                 rst,
  seq_cla_adder_ctrl_if.slave  bus
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = idx_width(NIBBLES);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  work_reg;
  logic [W-1:0]  work_nxt;
  logic          carry_reg;
  logic          carry_nxt;
  logic [W-1:0]  s_reg;
  logic          cout_reg;
  logic          done_reg;
  logic          busy_int;
  logic          last;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [3:0]    sum_nib;
  logic          slice_p;
  logic          slice_g;

  assign a_nib = a_reg[{idx, 2'b00} +: 4];
  assign b_nib = b_reg[{idx, 2'b00} +: 4];
  assign last  = (idx == IW'(NIBBLES - 1));

  bit_4_augment u_slice (
    .A   (a_nib),
    .B   (b_nib),
    .cin (carry_reg),
    .S   (sum_nib),
    .p   (slice_p),
    .g   (slice_g)
  );

  // Next work/carry include the slice result so the final nibble lands in S on DONE entry.
  always_comb begin
    work_nxt = work_reg;
    work_nxt[{idx, 2'b00} +: 4] = sum_nib;
    carry_nxt = slice_g | (slice_p & carry_reg);
  end

  always_comb begin
    state_nxt = state;
    busy_int  = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = ADD;
      ADD: begin
        busy_int = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy_int  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      carry_reg <= 1'b0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.A;
            b_reg     <= bus.B;
            carry_reg <= bus.cin;
            idx       <= '0;
          end
        end
        ADD: begin
          work_reg  <= work_nxt;
          carry_reg <= carry_nxt;
          if (last) begin
            s_reg    <= work_nxt;
            cout_reg <= carry_nxt;
            done_reg <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.S    = s_reg;
  assign bus.cout = cout_reg;
  assign bus.busy = busy_int;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_seq_cla_adder_ctrl.sv
// Directed and randomized checks of the sequential CLA adder: latency, result, start filtering, reset abort.
module tb_seq_cla_adder_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  seq_cla_adder_ctrl_if #(.NIBBLES(4)) bus ();

  seq_cla_adder_ctrl #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 16'h1111;
    bus.B     = 16'h2222;
    bus.cin   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.S !== 16'h0000) begin n_bad++; $display("FAIL reset_S got=%h exp=0000", bus.S); end
    n_cmp++; if (bus.cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_vectors;
    logic [15:0] ta [7] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hFFFF, 16'h7FFF};
    logic [15:0] tb [7] = '{16'h4321, 16'h0001, 16'h0000, 16'h8000, 16'h00F1, 16'hFFFF, 16'h0001};
    logic        tc [7] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1,     1'b0};
    logic [15:0] es [7] = '{16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h1001, 16'hFFFF, 16'h8000};
    logic        ec [7] = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = ta[i];
      bus.B     = tb[i];
      bus.cin   = tc[i];
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 16'hDEAD;
        bus.B     = 16'hBEEF;
        n_cmp++;
        if (bus.done !== 1'(c == 5)) begin
          n_bad++; $display("FAIL vec%0d_done_c%0d got=%b exp=%b", i, c, bus.done, (c == 5));
        end
        if (c == 5) begin
          n_cmp++; if (bus.S !== es[i]) begin n_bad++; $display("FAIL vec%0d_S got=%h exp=%h", i, bus.S, es[i]); end
          n_cmp++; if (bus.cout !== ec[i]) begin n_bad++; $display("FAIL vec%0d_cout got=%b exp=%b", i, bus.cout, ec[i]); end
          n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL vec%0d_busy_done got=%b exp=1", i, bus.busy); end
        end
        if (c == 6) begin
          n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL vec%0d_busy_idle got=%b exp=0", i, bus.busy); end
          n_cmp++; if (bus.S !== es[i]) begin n_bad++; $display("FAIL vec%0d_S_hold got=%h exp=%h", i, bus.S, es[i]); end
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    int dones = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 0) begin
        bus.start = 1'b1; bus.A = 16'h0001; bus.B = 16'h0001; bus.cin = 1'b0;
      end else if (c == 2 || c == 5 || c == 6) begin
        bus.start = 1'b1; bus.A = 16'hAAAA; bus.B = 16'h5555; bus.cin = 1'b0;
      end else if (c == 3) begin
        bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.cin = 1'b1;
      end
      if (c >= 1 && c <= 5 && bus.done === 1'b1) dones++;
      if (c == 5) begin
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL ign_done_c5 got=%b exp=1", bus.done); end
        n_cmp++; if (bus.S !== 16'h0002) begin n_bad++; $display("FAIL ign_S got=%h exp=0002", bus.S); end
        n_cmp++; if (bus.cout !== 1'b0) begin n_bad++; $display("FAIL ign_cout got=%b exp=0", bus.cout); end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
      end
      if (c == 6) begin
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy_c6 got=%b exp=0", bus.busy); end
      end
      if (c == 10) begin
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL ign_done_c10 got=%b exp=0", bus.done); end
      end
      if (c == 11) begin
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL ign_done_c11 got=%b exp=1", bus.done); end
        n_cmp++; if (bus.S !== 16'hFFFF) begin n_bad++; $display("FAIL ign_S2 got=%h exp=ffff", bus.S); end
        n_cmp++; if (bus.cout !== 1'b0) begin n_bad++; $display("FAIL ign_cout2 got=%b exp=0", bus.cout); end
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      rst       = 1'b0;
      if (c == 0) begin
        bus.start = 1'b1; bus.A = 16'h00FF; bus.B = 16'h0001; bus.cin = 1'b0;
      end
      if (c == 3) begin
        rst = 1'b1; bus.start = 1'b1; bus.A = 16'h1234; bus.B = 16'h1111;
      end
      if (c >= 4) begin
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done_c%0d got=%b exp=0", c, bus.done); end
        n_cmp++; if (bus.S !== 16'h0000) begin n_bad++; $display("FAIL rstmid_S_c%0d got=%h exp=0000", c, bus.S); end
        n_cmp++; if (bus.cout !== 1'b0) begin n_bad++; $display("FAIL rstmid_cout_c%0d got=%b exp=0", c, bus.cout); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_c%0d got=%b exp=0", c, bus.busy); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [16:0] ref_sum;
    int          lat;
    for (int n = 0; n < 1000; n++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, a} + {1'b0, b} + 17'(ci);
      @(negedge clk);
      bus.start = 1'b1; bus.A = a; bus.B = b; bus.cin = ci;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        bus.start = 1'($urandom_range(0, 1));
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
        bus.cin   = 1'($urandom_range(0, 1));
      end while (bus.done !== 1'b1 && lat < 20);
      bus.start = 1'b0;
      n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d exp=5", n, lat); end
      n_cmp++; if (bus.S !== ref_sum[15:0]) begin n_bad++; $display("FAIL rnd%0d_S got=%h exp=%h", n, bus.S, ref_sum[15:0]); end
      n_cmp++; if (bus.cout !== ref_sum[16]) begin n_bad++; $display("FAIL rnd%0d_cout got=%b exp=%b", n, bus.cout, ref_sum[16]); end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_vectors();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
